// File: rtl/pp_fetch_stage_pkg.sv
// Shared pipeline definitions: data width, default bubble word and fetch-state encoding.
package pp_fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_PEND = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pp_ifid_reg.sv
// IF/ID pipeline register. Priority: reset, bubble (keeps PCs), hold, load.
module pp_ifid_reg
    import pp_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            bubble_i,
    input  logic            hold_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc4_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bubble_i) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            inst_d  = inst_i;
            pc_d    = pc_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pp_fetch_stage.sv
// Fetch stage: PC register, next-PC mux, stalled-redirect holding, IF/ID register.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module pp_fetch_stage
    import pp_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            Clk,
    input  logic            Clrn,
    input  logic            Stall,
    input  logic            Flush,
    input  logic            Redirect,
    input  logic [XLEN-1:0] Redirect_PC,
    input  logic [XLEN-1:0] IMem_Data,
    output logic [XLEN-1:0] IMem_Addr,
    output logic [XLEN-1:0] I_PC,
    output logic [XLEN-1:0] I_Inst,
    output logic [XLEN-1:0] Inst,
    output logic [XLEN-1:0] D_PC,
    output logic [XLEN-1:0] D_PC4,
    output logic            D_Valid,
    output logic [XLEN-1:0] Perf_Fetch,
    output logic [XLEN-1:0] Perf_Stall,
    output logic [XLEN-1:0] Perf_Redir
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] pc_plus4;
    logic            ifid_bubble;

    // Targets are word aligned; the low two bits are ignored.
    assign redir_pc = Redirect_PC & ~32'h0000_0003;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        pc_d      = pc_q;
        case (state_q)
            FS_RUN: begin
                if (Redirect && Stall) begin
                    state_d   = FS_PEND;
                    pend_pc_d = redir_pc;
                end
            end
            FS_PEND: begin
                if (Stall) begin
                    if (Redirect) pend_pc_d = redir_pc;
                end else begin
                    state_d = FS_RUN;
                end
            end
            default: state_d = FS_RUN;
        endcase
        if (!Stall) begin
            if (Redirect)                 pc_d = redir_pc;
            else if (state_q == FS_PEND)  pc_d = pend_pc_q;
            else                          pc_d = pc_plus4;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state_q   <= FS_RUN;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // The word at PC is on the wrong path whenever a redirect is taking effect.
    assign ifid_bubble = Flush | (~Stall & (Redirect | (state_q == FS_PEND)));

    pp_ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk_i    (Clk),
        .rst_ni   (Clrn),
        .bubble_i (ifid_bubble),
        .hold_i   (Stall),
        .inst_i   (IMem_Data),
        .pc_i     (pc_q),
        .pc4_i    (pc_plus4),
        .inst_o   (Inst),
        .pc_o     (D_PC),
        .pc4_o    (D_PC4),
        .valid_o  (D_Valid)
    );

    assign IMem_Addr = pc_q;
    assign I_PC      = pc_q;
    assign I_Inst    = IMem_Data;

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] perf_fetch_q, perf_fetch_d;
    logic [XLEN-1:0] perf_stall_q, perf_stall_d;
    logic [XLEN-1:0] perf_redir_q, perf_redir_d;
    logic            fetch_load;

    assign fetch_load   = ~ifid_bubble & ~Stall;
    assign perf_fetch_d = perf_fetch_q + {{(XLEN-1){1'b0}}, fetch_load};
    assign perf_stall_d = perf_stall_q + {{(XLEN-1){1'b0}}, Stall};
    assign perf_redir_d = perf_redir_q + {{(XLEN-1){1'b0}}, Redirect};

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
            perf_redir_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    assign Perf_Fetch = perf_fetch_q;
    assign Perf_Stall = perf_stall_q;
    assign Perf_Redir = perf_redir_q;
`else
    assign Perf_Fetch = '0;
    assign Perf_Stall = '0;
    assign Perf_Redir = '0;
`endif

endmodule

// File: tb/tb_pp_fetch_stage.sv
// Directed bench for pp_fetch_stage; ROM word at address A is 32'h2000_0000 + A/4.
module tb_pp_fetch_stage;

    logic        Clk = 1'b0;
    logic        Clrn, Stall, Flush, Redirect;
    logic [31:0] Redirect_PC, IMem_Data, IMem_Addr, I_PC, I_Inst;
    logic [31:0] Inst, D_PC, D_PC4, Perf_Fetch, Perf_Stall, Perf_Redir;
    logic        D_Valid;

    int          n_vec = 0;
    int          n_err = 0;
    logic [128:0] got, exp;
    logic [95:0]  pgot, pexp;

    localparam logic [31:0] NOP = 32'h0000_0000;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h2000_0000 + (a >> 2);
    endfunction

    assign IMem_Data = rom(IMem_Addr);

    pp_fetch_stage dut (
        .Clk(Clk), .Clrn(Clrn), .Stall(Stall), .Flush(Flush),
        .Redirect(Redirect), .Redirect_PC(Redirect_PC), .IMem_Data(IMem_Data),
        .IMem_Addr(IMem_Addr), .I_PC(I_PC), .I_Inst(I_Inst), .Inst(Inst),
        .D_PC(D_PC), .D_PC4(D_PC4), .D_Valid(D_Valid),
        .Perf_Fetch(Perf_Fetch), .Perf_Stall(Perf_Stall), .Perf_Redir(Perf_Redir)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Clrn = 1'b0; Stall = 1'b0; Flush = 1'b0; Redirect = 1'b0; Redirect_PC = '0;
        tick();
        tick();
        Clrn = 1'b1;
    endtask

    task automatic test_reset();
        Clrn = 1'b0; Stall = 1'b0; Flush = 1'b0; Redirect = 1'b0; Redirect_PC = '0;
        tick();
        tick();
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h0, NOP, 32'h0, 32'h0, 1'b0};
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", got, exp);
        end
        n_vec++;
        pgot = {Perf_Fetch, Perf_Stall, Perf_Redir};
        if (pgot !== 96'h0) begin
            n_err++;
            $display("FAIL reset_perf: got %h expected 0", pgot);
        end
        n_vec++;
        if ({IMem_Addr, I_Inst} !== {32'h0, rom(32'h0)}) begin
            n_err++;
            $display("FAIL reset_imem: got %h/%h expected 0/%h", IMem_Addr, I_Inst, rom(32'h0));
        end
        Clrn = 1'b1;
    endtask

    task automatic test_free_run();
        // Reset left IF/ID empty; the first edge after release latches RESET_PC.
        n_vec++;
        if ({I_PC, D_Valid} !== {32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL free_run_start: got pc %h v %b expected pc 0 v 0", I_PC, D_Valid);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_vec++;
            got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
            exp = {32'(4*k), rom(32'(4*(k-1))), 32'(4*(k-1)), 32'(4*k), 1'b1};
            if (got !== exp) begin
                n_err++;
                $display("FAIL free_run_%0d: got %h expected %h", k, got, exp);
            end
        end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++;
            got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
            exp = {32'h10, rom(32'hC), 32'hC, 32'h10, 1'b1};
            if (got !== exp) begin
                n_err++;
                $display("FAIL stall_hold_%0d: got %h expected %h", k, got, exp);
            end
        end
        Stall = 1'b0;
        tick();
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h14, rom(32'h10), 32'h10, 32'h14, 1'b1};
        if (got !== exp) begin
            n_err++;
            $display("FAIL stall_resume: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        tick();
        tick();
        // PC is now 8; low target bits must be ignored.
        Redirect = 1'b1; Redirect_PC = 32'h43;
        tick();
        Redirect = 1'b0;
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h40, NOP, 32'h4, 32'h8, 1'b0};
        if (got !== exp) begin
            n_err++;
            $display("FAIL redirect_bubble: got %h expected %h", got, exp);
        end
        tick();
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h44, rom(32'h40), 32'h40, 32'h44, 1'b1};
        if (got !== exp) begin
            n_err++;
            $display("FAIL redirect_target: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_pend();
        Stall = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h80;
        tick();
        Redirect = 1'b0;
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h44, rom(32'h40), 32'h40, 32'h44, 1'b1};
        if (got !== exp) begin
            n_err++;
            $display("FAIL pend_stall_hold: got %h expected %h", got, exp);
        end
        tick();
        Redirect = 1'b1; Redirect_PC = 32'h93;
        tick();
        Stall = 1'b0; Redirect = 1'b0;
        tick();
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h90, NOP, 32'h40, 32'h44, 1'b0};
        if (got !== exp) begin
            n_err++;
            $display("FAIL pend_newest_wins: got %h expected %h", got, exp);
        end
        tick();
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h94, rom(32'h90), 32'h90, 32'h94, 1'b1};
        if (got !== exp) begin
            n_err++;
            $display("FAIL pend_target: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_flush_stall();
        Stall = 1'b1; Flush = 1'b1;
        tick();
        Stall = 1'b0; Flush = 1'b0;
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h94, NOP, 32'h90, 32'h94, 1'b0};
        if (got !== exp) begin
            n_err++;
            $display("FAIL flush_stall: got %h expected %h", got, exp);
        end
        tick();
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h98, rom(32'h94), 32'h94, 32'h98, 1'b1};
        if (got !== exp) begin
            n_err++;
            $display("FAIL flush_resume: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_redirect_over_pend();
        Stall = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h200;
        tick();
        Stall = 1'b0; Redirect_PC = 32'h300;
        tick();
        Redirect = 1'b0;
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h300, NOP, 32'h94, 32'h98, 1'b0};
        if (got !== exp) begin
            n_err++;
            $display("FAIL redirect_over_pend: got %h expected %h", got, exp);
        end
        tick();
        n_vec++;
        if ({I_PC, D_PC, D_Valid} !== {32'h304, 32'h300, 1'b1}) begin
            n_err++;
            $display("FAIL redirect_over_pend_next: got %h/%h/%b expected 304/300/1", I_PC, D_PC, D_Valid);
        end
    endtask

    task automatic test_wrap();
        Redirect = 1'b1; Redirect_PC = 32'hFFFF_FFFC;
        tick();
        Redirect = 1'b0;
        n_vec++;
        if (I_PC !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_target: got %h expected fffffffc", I_PC);
        end
        tick();
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h0, 32'h5FFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1'b1};
        if (got !== exp) begin
            n_err++;
            $display("FAIL wrap_around: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_reset_in_pend();
        Stall = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h500;
        tick();
        Clrn = 1'b0; Stall = 1'b0; Redirect = 1'b0;
        tick();
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h0, NOP, 32'h0, 32'h0, 1'b0};
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_in_pend: got %h expected %h", got, exp);
        end
        n_vec++;
        pgot = {Perf_Fetch, Perf_Stall, Perf_Redir};
        if (pgot !== 96'h0) begin
            n_err++;
            $display("FAIL reset_in_pend_perf: got %h expected 0", pgot);
        end
        Clrn = 1'b1;
        tick();
        n_vec++;
        got = {I_PC, Inst, D_PC, D_PC4, D_Valid};
        exp = {32'h4, rom(32'h0), 32'h0, 32'h4, 1'b1};
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_drops_pend: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_perf();
        do_reset();
        tick(); tick(); tick();
        Stall = 1'b1;
        tick(); tick();
        Stall = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h40;
        tick();
        Redirect = 1'b0;
        tick();
`ifdef FETCH_PERF_EN
        pexp = {32'd4, 32'd2, 32'd1};
`else
        pexp = 96'h0;
`endif
        n_vec++;
        pgot = {Perf_Fetch, Perf_Stall, Perf_Redir};
        if (pgot !== pexp) begin
            n_err++;
            $display("FAIL perf_counts: got %h expected %h", pgot, pexp);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_pend();
        test_flush_stall();
        test_redirect_over_pend();
        test_wrap();
        test_reset_in_pend();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
